// File: rtl/core_seq.sv
// core_seq: instruction sequencer for the 8x8 MAC core.
// Takes one job (weight tile base, activation base, psum base, activation
// count) and emits the 34-bit core instruction bundle cycle by cycle:
// weight fetch into L0, kernel load, activation execute with psum
// write-back, and an optional OFIFO drain.
//
// Optional feature macro: CORE_SEQ_ORD_EN
//   defined   - ORD state after EXEC drains the OFIFO; inst[6] is driven
//               combinationally from i_ofifo_valid while draining.
//   undefined - EXEC goes straight to DONE; inst[6] is constant 0.
//
// inst layout (same as core):
//   [33] acc  [32] CEN_pmem  [31] WEN_pmem  [30:20] A_pmem
//   [19] CEN_xmem  [18] WEN_xmem  [17:7] A_xmem
//   [6] ofifo_rd  [5] ififo_wr  [4] ififo_rd  [3] l0_rd  [2] l0_wr
//   [1] execute  [0] load
module core_seq #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int LAT    = ROW + COL,
    parameter int CNT_BW = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [10:0]       i_w_base,
    input  logic [10:0]       i_x_base,
    input  logic [10:0]       i_p_base,
    input  logic [CNT_BW-1:0] i_n_act,
    input  logic              i_acc_en,
    input  logic              i_ofifo_valid,
    output logic [33:0]       o_inst,
    output logic              o_busy,
    output logic              o_done
);

    // Phase counter must hold n_act+lat and row without overflow.
    localparam int K_W = $clog2((1 << CNT_BW) + LAT + ROW + 2);

    // Idle pattern: both memories disabled, no core activity.
    localparam logic [33:0] IP = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WFETCH,
        S_KLOAD,
        S_EXEC,
        S_ORD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [K_W-1:0]    r_k;
    logic [K_W-1:0]    w_k_nxt;
    logic              w_latch;

    logic [10:0]       r_w_base;
    logic [10:0]       r_x_base;
    logic [10:0]       r_p_base;
    logic [CNT_BW-1:0] r_n_act;
    logic              r_acc_en;

    logic [33:0]       r_inst;
    logic [33:0]       w_inst_nxt;
    logic              r_busy;
    logic              r_done;

    // Job fields as they will be after the coming edge, so that the first
    // WFETCH cycle already carries the freshly latched base address.
    logic [10:0]       w_wb;
    logic [10:0]       w_xb;
    logic [10:0]       w_pb;
    logic [CNT_BW-1:0] w_n;
    logic              w_acc;
    logic [K_W-1:0]    w_n_k;
    logic [K_W-1:0]    w_exec_last;
    logic [10:0]       w_kx;

    assign w_wb  = w_latch ? i_w_base : r_w_base;
    assign w_xb  = w_latch ? i_x_base : r_x_base;
    assign w_pb  = w_latch ? i_p_base : r_p_base;
    assign w_n   = w_latch ? i_n_act  : r_n_act;
    assign w_acc = w_latch ? i_acc_en : r_acc_en;
    assign w_n_k = K_W'(w_n);
    assign w_kx  = 11'(w_k_nxt);

    assign w_exec_last = K_W'(r_n_act) + K_W'(LAT);

`ifdef CORE_SEQ_ORD_EN
    logic [CNT_BW-1:0] r_rd_cnt;
    logic              w_ord_rd;

    assign w_ord_rd = (r_state == S_ORD) && i_ofifo_valid && (r_rd_cnt < r_n_act);
    assign o_inst   = {r_inst[33:7], w_ord_rd, r_inst[5:0]};

    // OFIFO read counter: cleared during EXEC, counts reads issued in ORD.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_cnt <= '0;
        end else if (r_state == S_EXEC) begin
            r_rd_cnt <= '0;
        end else if (w_ord_rd) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end
`else
    logic w_unused_ofifo;
    assign w_unused_ofifo = i_ofifo_valid;
    assign o_inst         = r_inst;
`endif

    assign o_busy = r_busy;
    assign o_done = r_done;

    // State, phase counter, job fields and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_w_base <= '0;
            r_x_base <= '0;
            r_p_base <= '0;
            r_n_act  <= '0;
            r_acc_en <= 1'b0;
            r_inst   <= IP;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            if (w_latch) begin
                r_w_base <= i_w_base;
                r_x_base <= i_x_base;
                r_p_base <= i_p_base;
                r_n_act  <= i_n_act;
                r_acc_en <= i_acc_en;
            end
            r_inst <= w_inst_nxt;
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    // Next state and phase counter; each phase restarts the counter at 0.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_latch     = 1'b1;
                    w_k_nxt     = '0;
                    w_state_nxt = (i_n_act == '0) ? S_DONE : S_WFETCH;
                end
            end
            S_WFETCH: begin
                if (r_k == K_W'(ROW)) begin
                    w_state_nxt = S_KLOAD;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
            S_KLOAD: begin
                if (r_k == K_W'(ROW - 1)) begin
                    w_state_nxt = S_EXEC;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
            S_EXEC: begin
                if (r_k == w_exec_last) begin
`ifdef CORE_SEQ_ORD_EN
                    w_state_nxt = S_ORD;
`else
                    w_state_nxt = S_DONE;
`endif
                    w_k_nxt = '0;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
`ifdef CORE_SEQ_ORD_EN
            S_ORD: begin
                // No timeout: wait for as many OFIFO reads as activations.
                if (r_rd_cnt == r_n_act) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    // Instruction bundle for the coming cycle, decoded from next state/counter.
    always_comb begin
        w_inst_nxt = IP;
        case (w_state_nxt)
            S_WFETCH: begin
                if (w_k_nxt < K_W'(ROW)) begin
                    w_inst_nxt[19]   = 1'b0;
                    w_inst_nxt[17:7] = w_wb + w_kx;
                end
                if (w_k_nxt != '0) begin
                    w_inst_nxt[2] = 1'b1;
                end
            end
            S_KLOAD: begin
                w_inst_nxt[0] = 1'b1;
            end
            S_EXEC: begin
                if (w_k_nxt < w_n_k) begin
                    w_inst_nxt[19]   = 1'b0;
                    w_inst_nxt[17:7] = w_xb + w_kx;
                end
                if ((w_k_nxt != '0) && (w_k_nxt <= w_n_k)) begin
                    w_inst_nxt[5] = 1'b1;
                    w_inst_nxt[1] = 1'b1;
                end
                // Psum for execute beat t appears lat cycles later.
                if ((w_k_nxt >= K_W'(LAT + 1)) && (w_k_nxt <= w_n_k + K_W'(LAT))) begin
                    w_inst_nxt[33]    = w_acc;
                    w_inst_nxt[32]    = 1'b0;
                    w_inst_nxt[31]    = 1'b0;
                    w_inst_nxt[30:20] = w_pb + 11'(w_k_nxt - K_W'(LAT + 1));
                end
            end
            default: begin
                w_inst_nxt = IP;
            end
        endcase
    end

endmodule

// File: doc/core_seq.md
# core_seq

Instruction sequencer for the 8x8 MAC core. Accepts one job: a weight tile, an activation stream and a psum destination. It then emits the 34-bit `inst` bundle cycle by cycle to drive the core through four steps:

- weight fetch into L0
- kernel load into the MAC array
- activation execute with psum write-back
- optional OFIFO drain

It replaces hand-written testbench instruction sequences and sits directly in front of `core`.

## Interface
- `row`, 8, MAC array rows; sets weight-fetch and kernel-load length
- `col`, 8, MAC array columns; documentation only (lat default derives from it)
- `lat`, 16, cycles from an execute beat to its psum being writable (row+col)
- `cnt_bw`, 8, width of the activation count
- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: asynchronous, active-high
- `start` input 1: job request, sampled only in IDLE
- `w_base` input 11: xmem base address of weight rows
- `x_base` input 11: xmem base address of activation rows
- `p_base` input 11: pmem base address for psum write-back
- `n_act` input cnt_bw: number of activation rows (0 legal)
- `acc_en` input 1: value driven on inst[33] during write-back
- `ofifo_valid` input 1: core OFIFO has data
- `inst` output 34: core instruction bundle, field layout identical to core
- `busy` output 1: high in every state except IDLE
- `done` output 1: one-cycle pulse at job end

## Operation
- Idle pattern IP: CEN_xmem=WEN_xmem=CEN_pmem=WEN_pmem=1, all other bits 0, i.e. 34'h1_800C_0000.
- In IDLE, `inst`=IP.
- `start`=1 in IDLE latches `w_base`, `x_base`, `p_base`, `n_act`, `acc_en`. Later changes are ignored until the next job.
- `start` outside IDLE is ignored.
- States: IDLE -> WFETCH -> KLOAD -> EXEC -> [ORD] -> DONE -> IDLE.
- If n_act=0: IDLE -> DONE directly, with no memory activity.
- Cycle index k=0 is the first cycle `inst` reflects a state. Any field not named below holds its IP value.
- WFETCH, k=0..row:
  - for k<row: xmem read (CEN=0,WEN=1), A_xmem=w_base+k
  - for k>=1: l0_wr=1
- KLOAD, k=0..row-1: load=1.
- EXEC, t=0..n_act+lat:
  - for t<n_act: xmem read, A_xmem=x_base+t
  - for 1<=t<=n_act: ififo_wr=1, execute=1
  - for lat+1<=t<=n_act+lat: pmem write (CEN=0,WEN=0), A_pmem=p_base+(t-1-lat), acc=acc_en
- ORD (only with the macro; see Configuration):
  - inst[6]=ofifo_valid AND (rd_cnt<n_act)
  - rd_cnt increments on each cycle inst[6]=1
  - leave after the cycle rd_cnt reaches n_act
  - no timeout
- DONE: one cycle, `inst`=IP, `done`=1. Next state IDLE.
- Addresses are 11-bit sums that wrap modulo 2048.
- Phase counters are wide enough for n_act+lat; no overflow for legal cnt_bw.

## Timing
- `inst` (except inst[6] in ORD), `busy` and `done` are registered.
- `start` sampled high at edge e gives WFETCH k=0 on `inst` after edge e; `busy` rises at the same edge.
- Job length without ORD: (row+1)+row+(n_act+lat+1)+1 cycles. With defaults and n_act=4: 39 cycles.
- n_act=0: `done` and `busy` high for exactly one cycle, starting one cycle after start.
- Reset values: `inst`=IP, `busy`=0, `done`=0. Counters and latched job fields are 0.
- Reset asserted mid-job forces IDLE and IP immediately (async). No pulse on `done`.
- `start` arriving in the DONE cycle is ignored; a new job is accepted only from IDLE.

## Configuration
- Macro `CORE_SEQ_ORD_EN`.
- Defined: the ORD state exists after EXEC. inst[6] is combinational from `ofifo_valid` as specified in Operation.
- Undefined: EXEC goes directly to DONE. inst[6] is constant 0 and `ofifo_valid` is unused.

## Test plan
- Reset: assert reset mid-clock -> `inst`=34'h1_800C_0000, `busy`=0, `done`=0 without waiting for an edge.
- Job with w_base=0, x_base=16, p_base=0, n_act=4, acc_en=0, defaults, macro off:
  - WFETCH A_xmem 0..7, l0_wr k=1..8
  - load for 8 cycles
  - execute at EXEC t=1..4
  - pmem writes to 0..3 at t=17..20
  - `done` pulses 38 cycles after start, in the 39th busy cycle.
- Same job with acc_en=1, p_base=2045, x_base=2046:
  - A_xmem reads 2046, 2047, 0, 1
  - A_pmem writes 2045, 2046, 2047, 0, each with inst[33]=1.
- `start` held high through a whole job -> exactly one job runs. A second job starts only from IDLE, on the cycle after `done` falls.
- n_act=0 -> single `done` pulse; CEN_xmem and CEN_pmem stay 1 throughout. Separately, reset at EXEC t=10 -> IP next, no `done`, next start runs cleanly.
- Macro on, n_act=4, `ofifo_valid` pattern 1,0,1,1,1,1 from ORD k=0 -> inst[6]=1,0,1,1,1,0. `done` follows once rd_cnt=4.
